// File: rtl/demux_stream_1_to_n.sv
// demux_stream_1_to_n
// Registered, handshaked 1-to-N stream demultiplexer. Each of the N = 2**sel_bits
// output channels owns a one-word holding slot {valid, data} with its own
// valid/ready handshake. A word goes either to one selected channel (unicast)
// or to every channel at once (broadcast, all-or-nothing).
module demux_stream_1_to_n #(
  parameter int bits     = 16,
  parameter int sel_bits = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [bits-1:0]                 in_data,
  input  logic [sel_bits-1:0]             in_select,
  input  logic                            in_bcast,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [bits*(2**sel_bits)-1:0]   out_data,
  output logic [(2**sel_bits)-1:0]        out_valid,
  input  logic [(2**sel_bits)-1:0]        out_ready,
  output logic                            busy
);

  localparam int N = 2**sel_bits;

  logic [N-1:0]      valid_q;
  logic [N-1:0]      valid_d;
  logic [bits*N-1:0] data_q;
  logic [bits*N-1:0] data_d;
  logic [N-1:0]      free;
  logic [N-1:0]      sel_onehot;
  logic [N-1:0]      load;
  logic              accept;

  // Slot availability, input ready and the per-slot load strobes for this cycle
  always_comb begin
    free       = ~valid_q | out_ready;
    sel_onehot = N'(1) << in_select;
    if (in_bcast) begin
      in_ready = &free;
    end else begin
      in_ready = free[in_select];
    end
    accept = in_valid & in_ready;
    load   = '0;
    if (accept) begin
      if (in_bcast) begin
        load = '1;
      end else begin
        load = sel_onehot;
      end
    end
  end

  // Next slot contents: a refill beats a drain; a drained slot keeps its last data
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < N; k++) begin
      valid_d[k] = load[k] | (valid_q[k] & ~out_ready[k]);
      if (load[k]) begin
        data_d[k*bits +: bits] = in_data;
      end
    end
  end

  // Slot registers, cleared immediately by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // Outputs come straight from the slot registers
  always_comb begin
    out_valid = valid_q;
    out_data  = data_q;
    busy      = |valid_q;
  end

endmodule

// File: tb/tb_demux_stream_1_to_n.sv
// Testbench for demux_stream_1_to_n (bits=16, sel_bits=4).
// Words expected to leave a channel are queued as they are driven and popped
// by a monitor whenever a channel completes an output handshake.
module tb_demux_stream_1_to_n;

  localparam int BITS = 16;
  localparam int SELB = 4;
  localparam int N    = 16;

  logic              clock;
  logic              reset;
  logic [BITS-1:0]   in_data;
  logic [SELB-1:0]   in_select;
  logic              in_bcast;
  logic              in_valid;
  logic              in_ready;
  logic [BITS*N-1:0] out_data;
  logic [N-1:0]      out_valid;
  logic [N-1:0]      out_ready;
  logic              busy;

  typedef struct packed {
    logic [3:0]  chan;
    logic [15:0] data;
  } sb_t;

  sb_t sb_q[$];
  int  checks   = 0;
  int  failures = 0;

  demux_stream_1_to_n #(.bits(BITS), .sel_bits(SELB)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_select(in_select),
    .in_bcast (in_bcast),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output monitor: every completed output handshake must match the queue head
  always @(negedge clock) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          sb_t e;
          checks++;
          if (sb_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL sb_unexpected chan=%0d got=%h expected=none", k, out_data[k*BITS +: BITS]);
          end else begin
            e = sb_q.pop_front();
            if (e.chan !== 4'(k) || out_data[k*BITS +: BITS] !== e.data) begin
              failures++;
              $display("[TB] FAIL sb_word got chan=%0d data=%h expected chan=%0d data=%h",
                       k, out_data[k*BITS +: BITS], e.chan, e.data);
            end
          end
        end
      end
    end
  end

  function automatic logic [15:0] chan_data(input int k);
    return out_data[k*BITS +: BITS];
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic b, input logic [3:0] s, input logic [15:0] d);
    in_valid  = v;
    in_bcast  = b;
    in_select = s;
    in_data   = d;
  endtask

  task automatic push(input logic [3:0] c, input logic [15:0] d);
    sb_t e;
    e.chan = c;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 16'h0000 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_initial out_valid=%h busy=%b expected 0000/0", out_valid, busy);
    end
    out_ready = '0;
    for (int s = 4; s < 8; s++) begin
      drive(1'b1, 1'b0, 4'(s), 16'h4000 + 16'(s));
      next_cycle();
    end
    drive(1'b0, 1'b0, 4'd0, 16'h0000);
    @(negedge clock);
    checks++;
    if (out_valid !== 16'h00F0) begin
      failures++;
      $display("[TB] FAIL reset_preload out_valid=%h expected 00f0", out_valid);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 16'h0000 || out_data !== '0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_async out_valid=%h in_ready=%b busy=%b data_nonzero=%b expected 0000/1/0/0",
               out_valid, in_ready, busy, |out_data);
    end
    next_cycle();
    reset = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_unicast();
    out_ready = '0;
    drive(1'b1, 1'b0, 4'd5, 16'hBEEF);
    push(4'd5, 16'hBEEF);
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL uni_ready5 in_ready=%b expected 1", in_ready);
    end
    next_cycle();
    drive(1'b1, 1'b0, 4'd5, 16'hCAFE);
    @(negedge clock);
    checks++;
    if (out_valid !== 16'h0020 || chan_data(5) !== 16'hBEEF || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL uni_load5 out_valid=%h ch5=%h busy=%b expected 0020/beef/1", out_valid, chan_data(5), busy);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL uni_full5 in_ready=%b expected 0", in_ready);
    end
    #1 in_select = 4'd6;
    push(4'd6, 16'hCAFE);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL uni_ready6 in_ready=%b expected 1", in_ready);
    end
    next_cycle();
    drive(1'b0, 1'b0, 4'd0, 16'h0000);
    @(negedge clock);
    checks++;
    if (out_valid !== 16'h0060 || chan_data(6) !== 16'hCAFE || chan_data(5) !== 16'hBEEF) begin
      failures++;
      $display("[TB] FAIL uni_load6 out_valid=%h ch5=%h ch6=%h expected 0060/beef/cafe",
               out_valid, chan_data(5), chan_data(6));
    end
    next_cycle();
    out_ready = 16'h0060;
    next_cycle();
    out_ready = '0;
    @(negedge clock);
    checks++;
    if (out_valid !== 16'h0000 || chan_data(5) !== 16'hBEEF) begin
      failures++;
      $display("[TB] FAIL uni_drained out_valid=%h ch5=%h expected 0000/beef", out_valid, chan_data(5));
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    out_ready = 16'h0008;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, 4'd3, 16'(i));
      push(4'd3, 16'(i));
      @(negedge clock);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stream_ready word=%0d in_ready=%b expected 1", i, in_ready);
      end
      if (i > 1) begin
        checks++;
        if (out_valid[3] !== 1'b1 || chan_data(3) !== 16'(i - 1)) begin
          failures++;
          $display("[TB] FAIL stream_latency word=%0d valid=%b ch3=%h expected 1/%h",
                   i, out_valid[3], chan_data(3), 16'(i - 1));
        end
      end
      next_cycle();
    end
    drive(1'b0, 1'b0, 4'd0, 16'h0000);
    next_cycle();
    out_ready = '0;
    @(negedge clock);
    checks++;
    if (out_valid !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL stream_end out_valid=%h expected 0000", out_valid);
    end
    next_cycle();
  endtask

  task automatic test_drain_refill();
    out_ready = '0;
    drive(1'b1, 1'b0, 4'd2, 16'h1111);
    push(4'd2, 16'h1111);
    next_cycle();
    out_ready = 16'h0004;
    drive(1'b1, 1'b0, 4'd2, 16'h2222);
    push(4'd2, 16'h2222);
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL refill_ready in_ready=%b expected 1", in_ready);
    end
    next_cycle();
    out_ready = '0;
    drive(1'b0, 1'b0, 4'd0, 16'h0000);
    @(negedge clock);
    checks++;
    if (out_valid !== 16'h0004 || chan_data(2) !== 16'h2222) begin
      failures++;
      $display("[TB] FAIL refill_data out_valid=%h ch2=%h expected 0004/2222", out_valid, chan_data(2));
    end
    next_cycle();
    out_ready = 16'h0004;
    next_cycle();
    out_ready = '0;
  endtask

  task automatic test_broadcast();
    out_ready = '0;
    drive(1'b1, 1'b0, 4'd9, 16'h9999);
    push(4'd9, 16'h9999);
    next_cycle();
    drive(1'b1, 1'b1, 4'd3, 16'hA5A5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bcast_blocked cycle=%0d in_ready=%b expected 0", c, in_ready);
      end
      next_cycle();
    end
    checks++;
    if (out_valid !== 16'h0200) begin
      failures++;
      $display("[TB] FAIL bcast_no_partial out_valid=%h expected 0200", out_valid);
    end
    out_ready = 16'h0200;
    for (int k = 0; k < N; k++) push(4'(k), 16'hA5A5);
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bcast_release in_ready=%b expected 1", in_ready);
    end
    next_cycle();
    out_ready = '0;
    drive(1'b0, 1'b0, 4'd0, 16'h0000);
    @(negedge clock);
    checks++;
    if (out_valid !== 16'hFFFF || out_data !== {16{16'hA5A5}} || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bcast_all out_valid=%h ch0=%h ch15=%h busy=%b expected ffff/a5a5/a5a5/1",
               out_valid, chan_data(0), chan_data(15), busy);
    end
    next_cycle();
    out_ready = 16'hFFFF;
    next_cycle();
    out_ready = '0;
    @(negedge clock);
    checks++;
    if (out_valid !== 16'h0000 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bcast_drained out_valid=%h busy=%b expected 0000/0", out_valid, busy);
    end
    next_cycle();
  endtask

  task automatic test_hold();
    out_ready = '0;
    drive(1'b1, 1'b0, 4'd0, 16'h0A0A);
    push(4'd0, 16'h0A0A);
    next_cycle();
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 1'b0, 4'd0, (c % 2 == 0) ? 16'hFFFF : 16'h5555);
      @(negedge clock);
      checks++;
      if (chan_data(0) !== 16'h0A0A || out_valid[0] !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL hold cycle=%0d ch0=%h valid=%b busy=%b in_ready=%b expected 0a0a/1/1/0",
                 c, chan_data(0), out_valid[0], busy, in_ready);
      end
      next_cycle();
    end
    drive(1'b0, 1'b0, 4'd0, 16'h0000);
    out_ready = 16'h0001;
    next_cycle();
    out_ready = '0;
    next_cycle();
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = '0;
    drive(1'b0, 1'b0, 4'd0, 16'h0000);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    test_reset();
    test_unicast();
    test_back_to_back();
    test_drain_refill();
    test_broadcast();
    test_hold();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL sb_leftover remaining=%0d expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
